wasca_mem_block_reader: RTL

WASCA_MEM_BLOCK_READER -- requirements
Module: wasca_mem_block_reader

---
 rtl/wasca_mem_pkg.sv | 14 +
 rtl/wasca_sync_fifo.sv | 59 +++++
 rtl/wasca_mem_block_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/wasca_mem_pkg.sv
// Shared types and constants for the WASCA memory block reader.
// Holds the reader FSM encoding and the memory read latency assumed by the datapath.
package wasca_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } reader_state_t;

  localparam int MEM_READ_LATENCY = 1;

endpackage

// File: rtl/wasca_sync_fifo.sv
// Single-clock FIFO with occupancy count and show-ahead read data.
// Pushes are dropped when full and pops are ignored when empty.
module wasca_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_wr_en,
  input  logic [WIDTH-1:0]       i_wr_data,
  input  logic                   i_rd_en,
  output logic [WIDTH-1:0]       o_rd_data,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push    = i_wr_en && (r_count != (PTR_W+1)'(DEPTH));
  assign w_pop     = i_rd_en && (r_count != '0);
  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  // Storage needs no reset: an entry is only visible once the count covers it.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/wasca_mem_block_reader.sv
// Reads a block of consecutive words from an Avalon-MM memory and streams them out
// through a small buffer; reads are throttled so the buffer can never overflow.
module wasca_mem_block_reader
  import wasca_mem_pkg::*;
#(
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address,
  output logic [3:0]        byteenable,
  output logic              chipselect,
  output logic              write,
  output logic [31:0]       writedata,
  output logic              clken,
  input  logic [31:0]       readdata,
  output logic [31:0]       out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int              CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W:0] MAX_WORDS = {1'b1, {ADDR_W{1'b0}}};

  reader_state_t                r_state;
  reader_state_t                w_next_state;
  logic [ADDR_W-1:0]            r_addr;
  logic [ADDR_W:0]              r_remaining;
  logic [MEM_READ_LATENCY-1:0]  r_pending;
  logic                         w_issue;
  logic                         w_capture;
  logic                         w_pop;
  logic                         w_fifo_empty;
  logic                         w_fifo_drained;
  logic [CNT_W-1:0]             w_fifo_count;
  logic [CNT_W:0]               w_inflight;
  logic [CNT_W:0]               w_occupancy;

  assign byteenable = 4'b1111;
  assign write      = 1'b0;
  assign writedata  = 32'd0;
  assign clken      = 1'b1;
  assign address    = r_addr;
  assign chipselect = w_issue;
  assign out_valid  = ~w_fifo_empty;
  assign w_pop      = out_valid & out_ready;
  assign w_capture  = r_pending[MEM_READ_LATENCY-1];

  // Words already requested count against buffer space so a full pipeline cannot overflow it.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < MEM_READ_LATENCY; i++) begin
      w_inflight = w_inflight + {{CNT_W{1'b0}}, r_pending[i]};
    end
    w_occupancy    = {1'b0, w_fifo_count} + w_inflight;
    w_fifo_drained = (w_inflight == '0) &&
                     (w_fifo_empty || ((w_fifo_count == CNT_W'(1)) && w_pop));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_issue      = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = (word_count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        busy    = 1'b1;
        w_issue = (r_remaining != '0) &&
                  (w_occupancy < (CNT_W+1)'(FIFO_DEPTH));
        if (w_issue && (r_remaining == (ADDR_W+1)'(1))) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (w_fifo_drained) begin
          w_next_state = ST_DONE;
        end
      end
      ST_DONE: begin
        busy         = 1'b1;
        done         = 1'b1;
        w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Clearing the pending pipe on reset discards any read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_pending   <= '0;
    end else begin
      r_pending[0] <= w_issue;
      for (int i = 1; i < MEM_READ_LATENCY; i++) begin
        r_pending[i] <= r_pending[i-1];
      end
      if ((r_state == ST_IDLE) && start) begin
        r_addr      <= base_addr;
        r_remaining <= (word_count > MAX_WORDS) ? MAX_WORDS : word_count;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_W'(1);
        r_remaining <= r_remaining - (ADDR_W+1)'(1);
      end
    end
  end

  wasca_sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_wr_en   (w_capture),
    .i_wr_data (readdata),
    .i_rd_en   (w_pop),
    .o_rd_data (out_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

endmodule
